// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection phase scheduler.
package traffic_pkg;

  localparam int unsigned TW      = 8;
  localparam int unsigned PHASE_W = 3;

  // Phase encoding, also exported on the debug phase port.
  typedef enum logic [PHASE_W-1:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5,
    FLASH     = 3'd6
  } phase_e;

  // Default phase durations in ticks, for integrators wiring constant timing.
  localparam logic [TW-1:0] DEF_GREEN_NS = 8'd20;
  localparam logic [TW-1:0] DEF_GREEN_EW = 8'd20;
  localparam logic [TW-1:0] DEF_YELLOW   = 8'd4;
  localparam logic [TW-1:0] DEF_ALLRED   = 8'd2;

  // Lamp payload, NS triple first then EW triple.
  typedef struct packed {
    logic r1;
    logic y1;
    logic g1;
    logic r2;
    logic y2;
    logic g2;
  } lamp_t;

  localparam lamp_t LAMP_NS_GREEN  = lamp_t'(6'b001_100);
  localparam lamp_t LAMP_NS_YELLOW = lamp_t'(6'b010_100);
  localparam lamp_t LAMP_EW_GREEN  = lamp_t'(6'b100_001);
  localparam lamp_t LAMP_EW_YELLOW = lamp_t'(6'b100_010);
  localparam lamp_t LAMP_ALLRED    = lamp_t'(6'b100_100);
  localparam lamp_t LAMP_DARK      = lamp_t'(6'b000_000);

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter for phase durations; holds at zero until reloaded.
module phase_timer #(
  parameter int unsigned TW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          dec,
  output logic          zero_c
);

  logic [TW-1:0] cnt_q;

  // Load has priority; decrement only on a tick while nonzero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - TW'(1);
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-road intersection phase scheduler with pedestrian service and flashing-red mode.
module traffic_phase_scheduler #(
  parameter int unsigned TW = traffic_pkg::TW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic [TW-1:0] green_ns_t,
  input  logic [TW-1:0] green_ew_t,
  input  logic [TW-1:0] yellow_t,
  input  logic [TW-1:0] allred_t,
  input  logic          veh_req_ns,
  input  logic          veh_req_ew,
  input  logic          ped_req_ns,
  input  logic          ped_req_ew,
  input  logic          flash_mode,
  output logic          R1,
  output logic          Y1,
  output logic          G1,
  output logic          R2,
  output logic          Y2,
  output logic          G2,
  output logic          walk_ns,
  output logic          walk_ew,
  output logic [2:0]    phase
);

  import traffic_pkg::*;

  // Timer reload value: a zero duration still occupies one tick.
  function automatic logic [TW-1:0] ld_val(input logic [TW-1:0] dur);
    return (dur == '0) ? '0 : dur - TW'(1);
  endfunction

  phase_e        state_q, state_d;
  lamp_t         lamp_q, lamp_d;
  logic          ped_ns_q, ped_ns_d;
  logic          ped_ew_q, ped_ew_d;
  logic          svc_ns_q, svc_ns_d;
  logic          svc_ew_q, svc_ew_d;
  logic          walk_ns_q, walk_ns_d;
  logic          walk_ew_q, walk_ew_d;
  logic          flash_red_q, flash_red_d;
  logic          load_c;
  logic [TW-1:0] load_val_c;
  logic          zero_c;
  logic          expire_c;
  logic          ns_enter_c;
  logic          ew_enter_c;

  phase_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load_c),
    .load_val (load_val_c),
    .dec      (tick),
    .zero_c   (zero_c)
  );

  assign expire_c = tick & zero_c;

  // Next phase, timer reload, pedestrian bookkeeping and lamp decode.
  always_comb begin
    state_d     = state_q;
    load_c      = 1'b0;
    load_val_c  = '0;
    lamp_d      = LAMP_ALLRED;
    flash_red_d = 1'b1;

    unique case (state_q)
      NS_GREEN: begin
        if (expire_c && (veh_req_ew || ped_ew_q)) begin
          state_d    = NS_YELLOW;
          load_c     = 1'b1;
          load_val_c = ld_val(yellow_t);
        end
      end
      NS_YELLOW: begin
        if (expire_c) begin
          state_d    = ALLRED_A;
          load_c     = 1'b1;
          load_val_c = ld_val(allred_t);
        end
      end
      ALLRED_A: begin
        if (expire_c) begin
          load_c = 1'b1;
          if (flash_mode) begin
            state_d = FLASH;
          end else begin
            state_d    = EW_GREEN;
            load_val_c = ld_val(green_ew_t);
          end
        end
      end
      EW_GREEN: begin
        if (expire_c && (veh_req_ns || ped_ns_q)) begin
          state_d    = EW_YELLOW;
          load_c     = 1'b1;
          load_val_c = ld_val(yellow_t);
        end
      end
      EW_YELLOW: begin
        if (expire_c) begin
          state_d    = ALLRED_B;
          load_c     = 1'b1;
          load_val_c = ld_val(allred_t);
        end
      end
      ALLRED_B: begin
        if (expire_c) begin
          load_c = 1'b1;
          if (flash_mode) begin
            state_d = FLASH;
          end else begin
            state_d    = NS_GREEN;
            load_val_c = ld_val(green_ns_t);
          end
        end
      end
      FLASH: begin
        if (tick && !flash_mode) begin
          state_d    = ALLRED_B;
          load_c     = 1'b1;
          load_val_c = ld_val(allred_t);
        end
      end
      default: begin
        state_d = ALLRED_B;
        load_c  = 1'b1;
      end
    endcase

    // A pulse coinciding with green entry is kept for the following green.
    ns_enter_c = (state_d == NS_GREEN) && (state_q != NS_GREEN);
    ew_enter_c = (state_d == EW_GREEN) && (state_q != EW_GREEN);
    ped_ns_d   = ped_req_ns | (ped_ns_q & ~ns_enter_c);
    ped_ew_d   = ped_req_ew | (ped_ew_q & ~ew_enter_c);
    svc_ns_d   = ns_enter_c ? ped_ns_q : svc_ns_q;
    svc_ew_d   = ew_enter_c ? ped_ew_q : svc_ew_q;
    walk_ns_d  = (state_d == NS_GREEN) && svc_ns_d;
    walk_ew_d  = (state_d == EW_GREEN) && svc_ew_d;

    // Flashing red starts lit on entry and toggles on every tick after.
    if (state_d == FLASH) begin
      if (state_q != FLASH) begin
        flash_red_d = 1'b1;
      end else if (tick) begin
        flash_red_d = ~flash_red_q;
      end else begin
        flash_red_d = flash_red_q;
      end
    end

    unique case (state_d)
      NS_GREEN:  lamp_d = LAMP_NS_GREEN;
      NS_YELLOW: lamp_d = LAMP_NS_YELLOW;
      EW_GREEN:  lamp_d = LAMP_EW_GREEN;
      EW_YELLOW: lamp_d = LAMP_EW_YELLOW;
      FLASH:     lamp_d = flash_red_d ? LAMP_ALLRED : LAMP_DARK;
      default:   lamp_d = LAMP_ALLRED;
    endcase
  end

  // State, latches and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ALLRED_B;
      lamp_q      <= LAMP_ALLRED;
      ped_ns_q    <= 1'b0;
      ped_ew_q    <= 1'b0;
      svc_ns_q    <= 1'b0;
      svc_ew_q    <= 1'b0;
      walk_ns_q   <= 1'b0;
      walk_ew_q   <= 1'b0;
      flash_red_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      lamp_q      <= lamp_d;
      ped_ns_q    <= ped_ns_d;
      ped_ew_q    <= ped_ew_d;
      svc_ns_q    <= svc_ns_d;
      svc_ew_q    <= svc_ew_d;
      walk_ns_q   <= walk_ns_d;
      walk_ew_q   <= walk_ew_d;
      flash_red_q <= flash_red_d;
    end
  end

  assign R1      = lamp_q.r1;
  assign Y1      = lamp_q.y1;
  assign G1      = lamp_q.g1;
  assign R2      = lamp_q.r2;
  assign Y2      = lamp_q.y2;
  assign G2      = lamp_q.g2;
  assign walk_ns = walk_ns_q;
  assign walk_ew = walk_ew_q;
  assign phase   = state_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench: stimulus queues expected output events, a monitor pops them on each output change.
module tb_traffic_phase_scheduler;

  localparam int unsigned TW = 8;

  localparam logic [2:0] P_NSG = 3'd0;
  localparam logic [2:0] P_NSY = 3'd1;
  localparam logic [2:0] P_ARA = 3'd2;
  localparam logic [2:0] P_EWG = 3'd3;
  localparam logic [2:0] P_EWY = 3'd4;
  localparam logic [2:0] P_ARB = 3'd5;
  localparam logic [2:0] P_FLS = 3'd6;

  // Lamp order {R1,Y1,G1,R2,Y2,G2}.
  localparam logic [5:0] L_NSG  = 6'b001_100;
  localparam logic [5:0] L_NSY  = 6'b010_100;
  localparam logic [5:0] L_EWG  = 6'b100_001;
  localparam logic [5:0] L_EWY  = 6'b100_010;
  localparam logic [5:0] L_AR   = 6'b100_100;
  localparam logic [5:0] L_DARK = 6'b000_000;

  typedef struct {
    int         id;
    int         tk;
    logic [2:0] ph;
    logic [5:0] lamps;
    logic [1:0] walk;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          tick;
  logic [TW-1:0] green_ns_t, green_ew_t, yellow_t, allred_t;
  logic          veh_req_ns, veh_req_ew, ped_req_ns, ped_req_ew, flash_mode;
  logic          R1, Y1, G1, R2, Y2, G2, walk_ns, walk_ew;
  logic [2:0]    phase;

  exp_t  exp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    tick_no = 0;
  int    safe_prints = 0;
  logic  mon_en = 1'b0;
  logic  chk_now = 1'b0;
  logic  safe_en = 1'b0;
  logic [12:0] cur, last;

  always #5 clk = ~clk;

  traffic_phase_scheduler #(.TW(TW)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .green_ns_t (green_ns_t),
    .green_ew_t (green_ew_t),
    .yellow_t   (yellow_t),
    .allred_t   (allred_t),
    .veh_req_ns (veh_req_ns),
    .veh_req_ew (veh_req_ew),
    .ped_req_ns (ped_req_ns),
    .ped_req_ew (ped_req_ew),
    .flash_mode (flash_mode),
    .R1         (R1),
    .Y1         (Y1),
    .G1         (G1),
    .R2         (R2),
    .Y2         (Y2),
    .G2         (G2),
    .walk_ns    (walk_ns),
    .walk_ew    (walk_ew),
    .phase      (phase)
  );

  // Monitor: pop and compare on every output change, plus the safety invariant each cycle.
  always @(negedge clk) begin
    exp_t e;
    cur = {phase, R1, Y1, G1, R2, Y2, G2, walk_ns, walk_ew};
    if (mon_en && ((cur !== last) || chk_now)) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output tick=%0d got phase=%0d lamps=%b walk=%b required=no change",
                 tick_no, cur[12:10], cur[7:2], cur[1:0]);
      end else begin
        e = exp_q.pop_front();
        if (((e.tk >= 0) && (e.tk != tick_no)) || (cur !== {e.ph, e.lamps, e.walk})) begin
          failures++;
          $display("FAIL event_%0d got tick=%0d phase=%0d lamps=%b walk=%b required tick=%0d phase=%0d lamps=%b walk=%b",
                   e.id, tick_no, cur[12:10], cur[7:2], cur[1:0], e.tk, e.ph, e.lamps, e.walk);
        end
      end
    end
    last = cur;
    if (safe_en) begin
      checks++;
      if (((G1 | Y1) & (G2 | Y2)) ||
          ((phase != P_FLS) && (($countones({R1, Y1, G1}) != 1) || ($countones({R2, Y2, G2}) != 1)))) begin
        failures++;
        if (safe_prints < 10) begin
          safe_prints++;
          $display("FAIL safety got phase=%0d lamps=%b required no conflicting or missing lamp",
                   phase, {R1, Y1, G1, R2, Y2, G2});
        end
      end
    end
  end

  task automatic push(input int id, input int tk, input logic [2:0] ph,
                      input logic [5:0] lamps, input logic [1:0] walk);
    exp_t e;
    e.id = id; e.tk = tk; e.ph = ph; e.lamps = lamps; e.walk = walk;
    exp_q.push_back(e);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1; tick = 1'b1; tick_no++;
      @(posedge clk); #1; tick = 1'b0;
    end
  endtask

  task automatic ped_pulse(input logic ns);
    @(posedge clk); #1;
    if (ns) ped_req_ns = 1'b1; else ped_req_ew = 1'b1;
    @(posedge clk); #1;
    ped_req_ns = 1'b0; ped_req_ew = 1'b0;
  endtask

  // Reset pulse with a checkpoint on the reset values, then release.
  task automatic scen_reset(input int id);
    mon_en = 1'b0;
    @(posedge clk); #3; reset = 1'b0;
    safe_en = 1'b1;
    repeat (2) @(posedge clk);
    #1; push(id, -1, P_ARB, L_AR, 2'b00); chk_now = 1'b1; mon_en = 1'b1;
    @(negedge clk); #1; chk_now = 1'b0;
    @(posedge clk); #1; reset = 1'b1; tick_no = 0;
  endtask

  task automatic drain(input int id);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_%0d got pending=%0d required pending=0", id, exp_q.size());
    end
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b0; tick = 1'b0;
    green_ns_t = '0; green_ew_t = '0; yellow_t = '0; allred_t = '0;
    veh_req_ns = 1'b0; veh_req_ew = 1'b0; ped_req_ns = 1'b0; ped_req_ew = 1'b0;
    flash_mode = 1'b0;

    // Basic cycle, EW rest, mid-phase duration changes take effect only at next load.
    green_ns_t = 8'd4; green_ew_t = 8'd3; yellow_t = 8'd2; allred_t = 8'd1;
    veh_req_ew = 1'b1; veh_req_ns = 1'b0;
    scen_reset(10);
    push(11, 1, P_NSG, L_NSG, 2'b00);
    push(12, 5, P_NSY, L_NSY, 2'b00);
    push(13, 7, P_ARA, L_AR,  2'b00);
    push(14, 8, P_EWG, L_EWG, 2'b00);
    ticks(2); green_ns_t = 8'd1;
    ticks(3); yellow_t = 8'd5;
    ticks(9);
    veh_req_ns = 1'b1;
    push(15, 15, P_EWY, L_EWY, 2'b00);
    push(16, 20, P_ARB, L_AR,  2'b00);
    push(17, 21, P_NSG, L_NSG, 2'b00);
    ticks(7);
    drain(1);

    // NS green rests without cross demand.
    green_ns_t = 8'd3; green_ew_t = 8'd2; yellow_t = 8'd1; allred_t = 8'd2;
    veh_req_ew = 1'b0; veh_req_ns = 1'b0;
    scen_reset(20);
    push(21, 1,  P_NSG, L_NSG, 2'b00);
    push(22, 11, P_NSY, L_NSY, 2'b00);
    push(23, 12, P_ARA, L_AR,  2'b00);
    push(24, 14, P_EWG, L_EWG, 2'b00);
    ticks(10);
    veh_req_ew = 1'b1;
    ticks(6);
    drain(2);

    // Pedestrian latches: served at the next own-direction green.
    green_ns_t = 8'd2; green_ew_t = 8'd2; yellow_t = 8'd1; allred_t = 8'd1;
    veh_req_ew = 1'b0; veh_req_ns = 1'b0;
    scen_reset(30);
    push(31, 1,  P_NSG, L_NSG, 2'b00);
    push(32, 3,  P_NSY, L_NSY, 2'b00);
    push(33, 4,  P_ARA, L_AR,  2'b00);
    push(34, 5,  P_EWG, L_EWG, 2'b01);
    push(35, 9,  P_EWY, L_EWY, 2'b00);
    push(36, 10, P_ARB, L_AR,  2'b00);
    push(37, 11, P_NSG, L_NSG, 2'b00);
    push(38, 13, P_NSY, L_NSY, 2'b00);
    push(39, 14, P_ARA, L_AR,  2'b00);
    push(40, 15, P_EWG, L_EWG, 2'b01);
    push(41, 17, P_EWY, L_EWY, 2'b00);
    push(42, 18, P_ARB, L_AR,  2'b00);
    push(43, 19, P_NSG, L_NSG, 2'b10);
    ticks(2); ped_pulse(1'b0);
    ticks(4); ped_pulse(1'b0);
    ticks(2); veh_req_ns = 1'b1;
    ticks(9); ped_pulse(1'b1);
    ticks(2);
    drain(3);

    // Flash requested in green is honoured only at all-red expiry.
    green_ns_t = 8'd2; green_ew_t = 8'd2; yellow_t = 8'd1; allred_t = 8'd2;
    veh_req_ew = 1'b1; veh_req_ns = 1'b1; flash_mode = 1'b0;
    scen_reset(50);
    push(51, 1,  P_NSG, L_NSG,  2'b00);
    push(52, 3,  P_NSY, L_NSY,  2'b00);
    push(53, 4,  P_ARA, L_AR,   2'b00);
    push(54, 6,  P_FLS, L_AR,   2'b00);
    push(55, 7,  P_FLS, L_DARK, 2'b00);
    push(56, 8,  P_FLS, L_AR,   2'b00);
    push(57, 9,  P_FLS, L_DARK, 2'b00);
    push(58, 10, P_ARB, L_AR,   2'b00);
    push(59, 12, P_NSG, L_NSG,  2'b00);
    ticks(1); flash_mode = 1'b1;
    ticks(8); flash_mode = 1'b0;
    ticks(3);
    drain(4);

    // Zero yellow lasts one tick; reset mid EW yellow acts without a clock edge.
    green_ns_t = 8'd1; green_ew_t = 8'd1; yellow_t = 8'd0; allred_t = 8'd1;
    veh_req_ew = 1'b1; veh_req_ns = 1'b1;
    scen_reset(60);
    push(61, 1,  P_NSG, L_NSG, 2'b00);
    push(62, 2,  P_NSY, L_NSY, 2'b00);
    push(63, 3,  P_ARA, L_AR,  2'b00);
    push(64, 4,  P_EWG, L_EWG, 2'b00);
    push(65, 5,  P_EWY, L_EWY, 2'b00);
    push(66, -1, P_ARB, L_AR,  2'b00);
    ticks(5);
    @(posedge clk); #3; reset = 1'b0;
    #1;
    checks++;
    if ((phase !== P_ARB) || ({R1, Y1, G1, R2, Y2, G2} !== L_AR) || ({walk_ns, walk_ew} !== 2'b00)) begin
      failures++;
      $display("FAIL async_reset got phase=%0d lamps=%b required phase=%0d lamps=%b",
               phase, {R1, Y1, G1, R2, Y2, G2}, P_ARB, L_AR);
    end
    repeat (2) @(posedge clk);
    #1; reset = 1'b1; tick_no = 0;
    drain(5);

    // Random soak against the lamp safety invariant only.
    scen_reset(70);
    mon_en = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 15) == 0) veh_req_ns = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) veh_req_ew = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        green_ns_t = 8'($urandom_range(0, 5));
        green_ew_t = 8'($urandom_range(0, 5));
        yellow_t   = 8'($urandom_range(0, 3));
        allred_t   = 8'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 199) == 0) flash_mode = ~flash_mode;
      @(posedge clk); #1;
      tick = 1'b1; tick_no++;
      ped_req_ns = ($urandom_range(0, 31) == 0);
      ped_req_ew = ($urandom_range(0, 31) == 0);
      @(posedge clk); #1;
      tick = 1'b0; ped_req_ns = 1'b0; ped_req_ew = 1'b0;
    end
    flash_mode = 1'b0;
    drain(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
